// File: rtl/wdt_multi_window_if.sv
// Config, kick and status bundle for wdt_multi_window.
// The master drives config/kick/clear; the slave (watchdog) drives irq/early/bite.
interface wdt_multi_window_if #(
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned CNT_WIDTH = 16,
   parameter int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) ();
   logic                 cfg_we;
   logic [CH_W-1:0]      cfg_ch;
   logic                 cfg_en;
   logic [CNT_WIDTH-1:0] cfg_timeout;
   logic [CNT_WIDTH-1:0] cfg_window;
   logic [NUM_CH-1:0]    kick;
   logic [NUM_CH-1:0]    irq_clr;
   logic [NUM_CH-1:0]    irq;
   logic [NUM_CH-1:0]    early;
   logic                 bite;

   modport master (
      output cfg_we, cfg_ch, cfg_en, cfg_timeout, cfg_window, kick, irq_clr,
      input  irq, early, bite
   );

   modport slave (
      input  cfg_we, cfg_ch, cfg_en, cfg_timeout, cfg_window, kick, irq_clr,
      output irq, early, bite
   );
endinterface

// File: rtl/wdt_multi_window.sv
// NUM_CH independent windowed watchdogs: warning irq on first expiry, shared sticky bite on second.
// Early-kick (window) detection is built only when the macro WDT_WINDOW_EN is defined.
module wdt_multi_window #(
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned CNT_WIDTH = 16,
   parameter int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rstn,
   wdt_multi_window_if.slave bus
);

   typedef enum logic [1:0] {
      S_DIS  = 2'd0,
      S_RUN  = 2'd1,
      S_WARN = 2'd2
   } state_e;

   logic [NUM_CH-1:0] irq_q, irq_d;
   logic [NUM_CH-1:0] bite_evt;
   logic              bite_q, bite_d;

`ifdef WDT_WINDOW_EN
   logic [NUM_CH-1:0] early_q, early_d;
`else
   logic unused_window;
   assign unused_window = ^bus.cfg_window;
`endif

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      state_e               state_q, state_d;
      logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
      logic [CNT_WIDTH-1:0] timeout_q, timeout_d;
      logic                 en_q, en_d;
      logic                 cfg_hit, active, expire, early_kick, set_evt;

      // Out-of-range channel selects never match any g and are dropped.
      assign cfg_hit = bus.cfg_we && (bus.cfg_ch == CH_W'(g));
      assign active  = en_q && (state_q != S_DIS);
      assign expire  = active && !bus.kick[g] && (cnt_q == timeout_q);

`ifdef WDT_WINDOW_EN
      logic [CNT_WIDTH-1:0] window_q;

      assign early_kick = active && bus.kick[g] && (cnt_q < window_q);
      assign early_d[g] = (early_q[g] && !bus.irq_clr[g]) || (!cfg_hit && early_kick);

      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            window_q <= '0;
         end else if (cfg_hit) begin
            window_q <= bus.cfg_window;
         end
      end
`else
      assign early_kick = 1'b0;
`endif

      // A config write overrides any kick or expiry on the same edge.
      assign set_evt     = !cfg_hit && (early_kick || expire);
      assign irq_d[g]    = (irq_q[g] && !bus.irq_clr[g]) || set_evt;
      assign bite_evt[g] = set_evt && (state_q == S_WARN);

      always_comb begin
         state_d   = state_q;
         cnt_d     = cnt_q;
         timeout_d = timeout_q;
         en_d      = en_q;
         if (cfg_hit) begin
            en_d      = bus.cfg_en;
            timeout_d = bus.cfg_timeout;
            cnt_d     = '0;
            state_d   = (bus.cfg_en && (bus.cfg_timeout != '0)) ? S_RUN : S_DIS;
         end else if (active) begin
            if (bus.kick[g] || expire) begin
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
            // A new warning event beats a clear arriving on the same edge.
            if (set_evt) begin
               state_d = S_WARN;
            end else if (bus.irq_clr[g] && (state_q == S_WARN)) begin
               state_d = S_RUN;
            end
         end else begin
            cnt_d = '0;
         end
      end

      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            state_q   <= S_DIS;
            cnt_q     <= '0;
            timeout_q <= '0;
            en_q      <= 1'b0;
         end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            en_q      <= en_d;
         end
      end
   end

   assign bite_d = bite_q || (|bite_evt);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         irq_q  <= '0;
         bite_q <= 1'b0;
      end else begin
         irq_q  <= irq_d;
         bite_q <= bite_d;
      end
   end

`ifdef WDT_WINDOW_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         early_q <= '0;
      end else begin
         early_q <= early_d;
      end
   end
   assign bus.early = early_q;
`else
   assign bus.early = '0;
`endif

   assign bus.irq  = irq_q;
   assign bus.bite = bite_q;

endmodule

// File: tb/tb_wdt_multi_window.sv
// Self-checking bench for wdt_multi_window: directed scenarios plus randomized traffic
// compared against a per-channel behavioural model of the watchdog rules.
module tb_wdt_multi_window;
   localparam int unsigned NCH = 4;
   localparam int unsigned CW  = 8;
   localparam int unsigned CHW = 2;
`ifdef WDT_WINDOW_EN
   localparam bit WIN_EN = 1'b1;
`else
   localparam bit WIN_EN = 1'b0;
`endif

   logic clk;
   logic rstn;
   int   n_cmp;
   int   n_err;

   wdt_multi_window_if #(.NUM_CH(NCH), .CNT_WIDTH(CW), .CH_W(CHW)) bus ();

   wdt_multi_window #(.NUM_CH(NCH), .CNT_WIDTH(CW), .CH_W(CHW)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: elapsed count, limits, armed/pending flags per channel.
   int           m_cnt  [NCH];
   int           m_to   [NCH];
   int           m_win  [NCH];
   bit           m_on   [NCH];
   bit           m_pend [NCH];
   logic [NCH-1:0] m_irq;
   logic [NCH-1:0] m_early;
   logic         m_bite;

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_cnt[c] = 0; m_to[c] = 0; m_win[c] = 0; m_on[c] = 0; m_pend[c] = 0;
      end
      m_irq = '0; m_early = '0; m_bite = 1'b0;
   endtask

   task automatic model_step();
      for (int c = 0; c < NCH; c++) begin
         bit ev_e, ev_x, was;
         ev_e = 0; ev_x = 0;
         if (bus.cfg_we && int'(bus.cfg_ch) == c) begin
            m_to[c]   = int'(bus.cfg_timeout);
            m_win[c]  = int'(bus.cfg_window);
            m_cnt[c]  = 0;
            m_on[c]   = bus.cfg_en && (m_to[c] != 0);
            m_pend[c] = 0;
            if (bus.irq_clr[c]) begin m_irq[c] = 1'b0; m_early[c] = 1'b0; end
            continue;
         end
         if (m_on[c]) begin
            if (bus.kick[c]) begin
               if (WIN_EN && m_cnt[c] < m_win[c]) ev_e = 1;
               m_cnt[c] = 0;
            end else if (m_cnt[c] == m_to[c]) begin
               ev_x = 1;
               m_cnt[c] = 0;
            end else begin
               m_cnt[c]++;
            end
         end
         was = m_pend[c];
         if (bus.irq_clr[c]) begin
            m_irq[c] = 1'b0; m_early[c] = 1'b0; m_pend[c] = 0;
         end
         if (ev_e || ev_x) begin
            if (was) m_bite = 1'b1;
            m_pend[c] = 1;
            m_irq[c]  = 1'b1;
            if (ev_e) m_early[c] = 1'b1;
         end
      end
   endtask

   // One clock: DUT and model see the same inputs, pulses are dropped afterwards.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      bus.cfg_we  = 1'b0;
      bus.kick    = '0;
      bus.irq_clr = '0;
   endtask

   task automatic cfg(input int ch, input bit en, input int to, input int win);
      bus.cfg_we      = 1'b1;
      bus.cfg_ch      = CHW'(ch);
      bus.cfg_en      = en;
      bus.cfg_timeout = CW'(to);
      bus.cfg_window  = CW'(win);
      tick();
   endtask

   task automatic do_reset();
      bus.cfg_we = 1'b0; bus.kick = '0; bus.irq_clr = '0;
      #2 rstn = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if (bus.irq !== 4'b0000) begin n_err++; $display("FAIL reset_irq: got %b want 0000", bus.irq); end
      n_cmp++;
      if (bus.early !== 4'b0000) begin n_err++; $display("FAIL reset_early: got %b want 0000", bus.early); end
      n_cmp++;
      if (bus.bite !== 1'b0) begin n_err++; $display("FAIL reset_bite: got %b want 0", bus.bite); end
   endtask

   task automatic test_basic_expiry();
      do_reset();
      cfg(0, 1'b1, 10, 0);
      for (int k = 1; k <= 22; k++) begin
         tick();
         n_cmp++;
         if (bus.irq[0] !== (k >= 11)) begin
            n_err++; $display("FAIL basic_irq0 cyc%0d: got %b want %b", k, bus.irq[0], (k >= 11));
         end
         n_cmp++;
         if (bus.bite !== (k >= 22)) begin
            n_err++; $display("FAIL basic_bite cyc%0d: got %b want %b", k, bus.bite, (k >= 22));
         end
      end
   endtask

   task automatic test_periodic_service();
      do_reset();
      cfg(1, 1'b1, 20, 5);
      for (int k = 1; k <= 200; k++) begin
         if (k % 8 == 0) bus.kick[1] = 1'b1;
         tick();
         n_cmp++;
         if ({bus.irq, bus.early, bus.bite} !== 9'b0) begin
            n_err++; $display("FAIL periodic cyc%0d: got irq=%b early=%b bite=%b want all 0",
                              k, bus.irq, bus.early, bus.bite);
         end
      end
   endtask

   task automatic test_early_kick();
      do_reset();
      cfg(2, 1'b1, 20, 10);
      repeat (3) tick();
      bus.kick[2] = 1'b1;
      tick();
      n_cmp++;
      if (bus.early[2] !== WIN_EN) begin n_err++; $display("FAIL early_flag: got %b want %b", bus.early[2], WIN_EN); end
      n_cmp++;
      if (bus.irq[2] !== WIN_EN) begin n_err++; $display("FAIL early_irq: got %b want %b", bus.irq[2], WIN_EN); end
      bus.irq_clr[2] = 1'b1;
      tick();
      n_cmp++;
      if ({bus.irq[2], bus.early[2]} !== 2'b00) begin
         n_err++; $display("FAIL early_clear: got irq=%b early=%b want 0 0", bus.irq[2], bus.early[2]);
      end
      // Back in RUN: next expiry only warns, it must not bite.
      for (int k = 1; k <= 20; k++) begin
         tick();
         n_cmp++;
         if (bus.irq !== m_irq || bus.bite !== m_bite) begin
            n_err++; $display("FAIL early_run cyc%0d: got irq=%b bite=%b want irq=%b bite=%b",
                              k, bus.irq, bus.bite, m_irq, m_bite);
         end
      end
      n_cmp++;
      if ({bus.irq[2], bus.bite} !== 2'b10) begin
         n_err++; $display("FAIL early_rerun: got irq2=%b bite=%b want 1 0", bus.irq[2], bus.bite);
      end
   endtask

   task automatic test_kick_at_expiry();
      do_reset();
      cfg(3, 1'b1, 15, 0);
      repeat (15) tick();
      bus.kick[3] = 1'b1;
      tick();
      n_cmp++;
      if (bus.irq[3] !== 1'b0) begin n_err++; $display("FAIL kick_at_exp: got %b want 0", bus.irq[3]); end
      for (int k = 1; k <= 15; k++) begin
         tick();
         n_cmp++;
         if (bus.irq[3] !== 1'b0) begin n_err++; $display("FAIL kick_restart cyc%0d: got %b want 0", k, bus.irq[3]); end
      end
      tick();
      n_cmp++;
      if (bus.irq[3] !== 1'b1) begin n_err++; $display("FAIL kick_reexpire: got %b want 1", bus.irq[3]); end
   endtask

   task automatic test_clear_collision();
      int k;
      do_reset();
      cfg(0, 1'b1, 10, 6);
      cfg(1, 1'b1, 20, 5);
      k = 0;
      while (!m_pend[0] && k < 30) begin
         k++;
         if (k % 8 == 0) bus.kick[1] = 1'b1;
         tick();
      end
      n_cmp++;
      if (bus.irq[0] !== 1'b1) begin n_err++; $display("FAIL coll_warn: got %b want 1", bus.irq[0]); end
      repeat (2) begin
         k++;
         if (k % 8 == 0) bus.kick[1] = 1'b1;
         tick();
      end
      bus.kick[0] = 1'b1;
      bus.irq_clr[0] = 1'b1;
      tick();
      n_cmp++;
      if (bus.irq[0] !== WIN_EN || bus.early[0] !== WIN_EN) begin
         n_err++; $display("FAIL coll_set_wins: got irq0=%b early0=%b want %b %b", bus.irq[0], bus.early[0], WIN_EN, WIN_EN);
      end
      n_cmp++;
      if (bus.bite !== WIN_EN) begin n_err++; $display("FAIL coll_bite: got %b want %b", bus.bite, WIN_EN); end
      n_cmp++;
      if ({bus.irq[1], bus.early[1]} !== 2'b00) begin
         n_err++; $display("FAIL coll_isolation: got irq1=%b early1=%b want 0 0", bus.irq[1], bus.early[1]);
      end
      n_cmp++;
      if (bus.irq !== m_irq || bus.early !== m_early) begin
         n_err++; $display("FAIL coll_model: got irq=%b early=%b want %b %b", bus.irq, bus.early, m_irq, m_early);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < NCH; c++) cfg(c, 1'b1, $urandom_range(30, 4), $urandom_range(8, 0));
      for (int k = 0; k < 800; k++) begin
         for (int c = 0; c < NCH; c++) begin
            bus.kick[c]    = ($urandom_range(11, 0) == 0);
            bus.irq_clr[c] = ($urandom_range(15, 0) == 0);
         end
         if ($urandom_range(39, 0) == 0) begin
            bus.cfg_we      = 1'b1;
            bus.cfg_ch      = CHW'($urandom_range(NCH - 1, 0));
            bus.cfg_en      = ($urandom_range(3, 0) != 0);
            bus.cfg_timeout = CW'($urandom_range(30, 0));
            bus.cfg_window  = CW'($urandom_range(25, 0));
         end
         tick();
         n_cmp++;
         if (bus.irq !== m_irq || bus.early !== m_early || bus.bite !== m_bite) begin
            n_err++; $display("FAIL random cyc%0d: got irq=%b early=%b bite=%b want irq=%b early=%b bite=%b",
                              k, bus.irq, bus.early, bus.bite, m_irq, m_early, m_bite);
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      cfg(0, 1'b1, 5, 0);
      cfg(1, 1'b1, 30, 0);
      cfg(2, 1'b1, 25, 0);
      repeat (14) tick();
      n_cmp++;
      if (bus.bite !== 1'b1) begin n_err++; $display("FAIL mid_pre_bite: got %b want 1", bus.bite); end
      #2 rstn = 1'b0;
      model_reset();
      #1;
      n_cmp++;
      if ({bus.irq, bus.early, bus.bite} !== 9'b0) begin
         n_err++; $display("FAIL mid_async: got irq=%b early=%b bite=%b want all 0", bus.irq, bus.early, bus.bite);
      end
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      for (int k = 0; k < 40; k++) begin
         bus.kick = NCH'($urandom_range(15, 0));
         tick();
         n_cmp++;
         if ({bus.irq, bus.early, bus.bite} !== 9'b0) begin
            n_err++; $display("FAIL mid_dis cyc%0d: got irq=%b early=%b bite=%b want all 0", k, bus.irq, bus.early, bus.bite);
         end
      end
      cfg(0, 1'b1, 5, 0);
      repeat (6) tick();
      n_cmp++;
      if (bus.irq[0] !== 1'b1) begin n_err++; $display("FAIL mid_reconfig: got %b want 1", bus.irq[0]); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time bound expired got running want finished");
      $fatal(1, "bench time bound expired");
   end

   initial begin
      n_cmp = 0;
      n_err = 0;
      rstn  = 1'b0;
      bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_en = 1'b0;
      bus.cfg_timeout = '0; bus.cfg_window = '0;
      bus.kick = '0; bus.irq_clr = '0;
      model_reset();
      test_reset();
      test_basic_expiry();
      test_periodic_service();
      test_early_kick();
      test_kick_at_expiry();
      test_clear_collision();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/wdt_multi_window.md
# wdt_multi_window

Multi-channel windowed watchdog, the parametrised successor to the single-channel watchdog/driver pair. Each of `NUM_CH` independent channels has a runtime-programmable timeout and open-window threshold, plus a per-channel kick input. A channel raises a warning interrupt on its first expiry and the shared `bite` on a second expiry while the warning is still pending. Early-kick (window) detection is compile-time selectable. The block sits between software-visible config/kick registers and the system reset controller.

## Interface
- `NUM_CH`, default 4: number of independent channels (1..32).
- `CNT_WIDTH`, default 16: width of the per-channel counter, timeout and window values.
- `CH_W`, default `$clog2(NUM_CH)` (min 1): width of the channel select.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `cfg_we`  in  1  config write strobe, one cycle.
- `cfg_ch`  in  `CH_W`  channel addressed by `cfg_we`.
- `cfg_en`  in  1  channel enable written with `cfg_we`.
- `cfg_timeout`  in  `CNT_WIDTH`  expiry count.
- `cfg_window`  in  `CNT_WIDTH`  first count at which a kick is legal.
- `kick`  in  `NUM_CH`  per-channel service pulse.
- `irq_clr`  in  `NUM_CH`  per-channel clear of `irq`/`early`.
- `irq`  out  `NUM_CH`  sticky warning interrupt per channel.
- `early`  out  `NUM_CH`  sticky early-kick flag per channel.
- `bite`  out  1  sticky system-reset request.

## Operation
- Per-channel state: counter `cnt`, registered `timeout`, `window`, `en`. FSM states are DIS, RUN, WARN.
- **Reset:** all channels go to DIS with `cnt`=0, `timeout`=0, `window`=0. `irq`=0, `early`=0, `bite`=0.
- **Config write:** `cfg_we` loads `en`/`timeout`/`window` into channel `cfg_ch` and clears `cnt`.
  - Next state: RUN if `en`=1 and `timeout`≠0, otherwise DIS.
  - `irq` and `early` are not changed by a config write.
  - An out-of-range `cfg_ch` is ignored.
- **DIS:** `cnt` holds 0. Kicks are ignored.
- **RUN/WARN counting:** `cnt` increments by 1 per cycle.
- **Legal kick:** a kick with `cnt` ≥ `window` sets `cnt` to 0. The state is unchanged.
- **Early kick:** a kick with `cnt` < `window` sets `early`=1 and `irq`=1, and sets `cnt` to 0.
  - From RUN the channel goes to WARN.
  - From WARN it sets `bite`.
- **Expiry:** `cnt`==`timeout` with no kick in the same cycle.
  - From RUN: `irq`=1, go to WARN, `cnt` set to 0.
  - From WARN: `bite`=1, stay in WARN, `cnt` set to 0.
- **Clear:** `irq_clr[i]` clears `irq[i]` and `early[i]`. In WARN it returns the channel to RUN.
- **`bite`:** once set, cleared only by `rstn`. It is the OR of all channel bite events.
- **Window wider than timeout:** `window` > `timeout` is legal. Every kick is then early.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- A config write at edge E0 gives `cnt`=0 after E0.
- With no kick, `irq` rises at edge E0+`timeout`+1.
- A kick sampled at edge E gives `cnt`=0 after E.
- An early flag or expiry is visible on `early`/`irq` immediately after the sampling edge (1-cycle latency).
- **Simultaneous events, one channel, same edge:**
  - Kick and `cnt`==`timeout`: the kick wins, and it is legal if `cnt` ≥ `window`.
  - `irq_clr` and a new irq/early event: the set wins, and the state is WARN.
  - `cfg_we` and a kick: the config write wins and the kick is dropped.
  - `cfg_we` and an expiry: the config write wins.
- Channels are fully independent. Simultaneous events on different channels are all processed in the same cycle.
- Counter arithmetic is unsigned `CNT_WIDTH`. `cnt` never exceeds `timeout`, so it cannot wrap.
- Asserting `rstn` mid-count returns everything to reset values asynchronously.

## Configuration
- `WDT_WINDOW_EN` defined: early-kick detection is active exactly as specified above.
- `WDT_WINDOW_EN` undefined:
  - `cfg_window` is ignored and the window registers are not built.
  - Every kick is legal.
  - `early` is tied to 0.
  - Bite arises only from expiry in WARN.

## Test plan
Bench parameters: `NUM_CH`=4, `CNT_WIDTH`=8.
- **Basic expiry:** reset, then config ch0 with en=1, timeout=10, window=0, and no kicks. `irq[0]` rises 11 cycles after the write and `bite` stays 0. The channel re-expires 11 cycles later and `bite`=1.
- **Periodic service:** ch1 with timeout=20, window=5, kicked every 8 cycles for 200 cycles. `irq`, `early` and `bite` all stay 0.
- **Early kick (`WDT_WINDOW_EN` defined):** ch2 with timeout=20, window=10, kicked at `cnt`=3. `early[2]`=1 and `irq[2]`=1 on the next cycle. `irq_clr[2]` clears both and the channel returns to RUN.
- **Kick at expiry:** ch3 with timeout=15, window=0, kicked exactly when `cnt`=15. `cnt` goes to 0 and no irq occurs.
- **Clear/set collision and isolation:** ch0 in WARN receives `irq_clr[0]` on the same edge as an early kick. `irq[0]` stays 1. Meanwhile ch1 is serviced normally and its outputs are unaffected.
- **Reset mid-operation:** assert `rstn`=0 with `bite`=1 and `cnt` values nonzero. All outputs are 0 asynchronously, and channels stay in DIS after release until reconfigured.
